// File: rtl/inst_mem_loader.sv
// -----------------------------------------------------------------------------
// inst_mem_loader
//
// Streams a program into instruction memory from a byte interface. Bytes are
// assembled little-endian into 32-bit words, and each completed word is
// written with a single-cycle strobe. The processor is held off fetch until
// the load completes.
//
// Handshake: a byte transfers on a rising edge where byte_valid and byte_ready
// are both 1. byte_ready depends only on FSM state, never on byte_valid, so
// the producer may hold byte_valid and byte_data until the transfer happens.
//
// Optional feature (macro CHECKSUM_EN): after the data, one extra checksum byte
// is taken in a CHECK state. error is set when (sum of data bytes + checksum
// byte) mod 256 != 0. Without the macro there is no CHECK state, no sum
// register, and error is tied to 0.
//
// Parameters
//   MAX_WORDS   instruction-memory depth in 32-bit words (up to 2047)
//
// Ports
//   clk         sole clock, rising edge
//   rst         synchronous active-high reset
//   start       begin a load; sampled only in IDLE or DONE
//   word_count  words to load; latched (clamped to MAX_WORDS) on start
//   byte_valid  byte_data is valid this cycle
//   byte_data   incoming program byte
//   byte_ready  loader accepts byte_data this cycle (LOAD/CHECK only)
//   mem_we      one-cycle write strobe per word
//   mem_addr    byte address of the written word (bits [1:0] = 0)
//   mem_wdata   word being written
//   cpu_hold    holds the processor off fetch (low only in DONE)
//   busy        load in progress (LOAD/CHECK)
//   done        load finished (DONE)
//   error       checksum mismatch, level
// -----------------------------------------------------------------------------
module inst_mem_loader #(
    parameter int MAX_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [10:0] word_count,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int          IDX_W   = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
    localparam logic [10:0] MAX_CNT = 11'(MAX_WORDS);

`ifdef CHECKSUM_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DONE  = 2'd3
    } state_t;
`endif

    state_t             state_q, state_d;
    logic [10:0]        count_q, count_d;
    logic [IDX_W-1:0]   word_idx_q, word_idx_d;
    logic [1:0]         byte_idx_q, byte_idx_d;
    // Only the low three bytes are stored; the fourth goes straight to mem_wdata.
    logic [23:0]        asm_q, asm_d;
    logic               mem_we_q, mem_we_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;
`ifdef CHECKSUM_EN
    logic [7:0]         sum_q, sum_d;
    logic [7:0]         sum_plus_byte;
    logic               error_q, error_d;
`endif

    logic byte_fire;
    logic last_word;

    assign byte_fire = byte_valid & byte_ready;
    assign last_word = (11'(word_idx_q) == (count_q - 11'd1));

`ifdef CHECKSUM_EN
    assign sum_plus_byte = sum_q + byte_data;
`endif

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        word_idx_d  = word_idx_q;
        byte_idx_d  = byte_idx_q;
        asm_d       = asm_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef CHECKSUM_EN
        sum_d       = sum_q;
        error_d     = error_q;
`endif

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    if (word_count == 11'd0) begin
                        state_d = DONE;
                    end else begin
                        state_d    = LOAD;
                        count_d    = (word_count > MAX_CNT) ? MAX_CNT : word_count;
                        word_idx_d = '0;
                        byte_idx_d = 2'd0;
                        asm_d      = 24'd0;
`ifdef CHECKSUM_EN
                        sum_d      = 8'd0;
`endif
                    end
`ifdef CHECKSUM_EN
                    error_d = 1'b0;
`endif
                end
            end

            LOAD: begin
                if (byte_fire) begin
                    byte_idx_d = byte_idx_q + 2'd1;
`ifdef CHECKSUM_EN
                    sum_d      = sum_plus_byte;
`endif
                    case (byte_idx_q)
                        2'd0: asm_d[7:0]   = byte_data;
                        2'd1: asm_d[15:8]  = byte_data;
                        2'd2: asm_d[23:16] = byte_data;
                        default: begin
                            // Word complete: the write strobe appears next cycle
                            // while the next word's bytes keep flowing in.
                            mem_we_d    = 1'b1;
                            mem_addr_d  = 32'(word_idx_q) << 2;
                            mem_wdata_d = {byte_data, asm_q};
                            if (last_word) begin
`ifdef CHECKSUM_EN
                                state_d = CHECK;
`else
                                state_d = DONE;
`endif
                            end else begin
                                // Index is held on the last word so it never
                                // passes MAX_WORDS-1.
                                word_idx_d = word_idx_q + 1'b1;
                            end
                        end
                    endcase
                end
            end

`ifdef CHECKSUM_EN
            CHECK: begin
                if (byte_fire) begin
                    error_d = (sum_plus_byte != 8'd0);
                    state_d = DONE;
                end
            end
`endif

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= 11'd0;
            word_idx_q  <= '0;
            byte_idx_q  <= 2'd0;
            asm_q       <= 24'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
`ifdef CHECKSUM_EN
            sum_q       <= 8'd0;
            error_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            word_idx_q  <= word_idx_d;
            byte_idx_q  <= byte_idx_d;
            asm_q       <= asm_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
`ifdef CHECKSUM_EN
            sum_q       <= sum_d;
            error_q     <= error_d;
`endif
        end
    end

    // State-decoded outputs.
`ifdef CHECKSUM_EN
    assign byte_ready = (state_q == LOAD) || (state_q == CHECK);
    assign error      = error_q;
`else
    assign byte_ready = (state_q == LOAD);
    assign error      = 1'b0;
`endif
    assign busy      = byte_ready;
    assign done      = (state_q == DONE);
    assign cpu_hold  = (state_q != DONE);
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// -----------------------------------------------------------------------------
// tb_inst_mem_loader
//
// Directed bench for inst_mem_loader. Expected memory writes ({addr, data}) are
// queued as the final byte of each word is driven and are checked by a write
// monitor on the falling edge. Status outputs are checked #1 after rising
// edges. Build with +define+CHECKSUM_EN to exercise the checksum stage.
// -----------------------------------------------------------------------------
module tb_inst_mem_loader;

    localparam int W = 64;

    logic        clk;
    logic        rst;
    logic        start;
    logic [10:0] word_count;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;

    logic [W-1:0] exp_q[$];

    int          vec_cnt = 0;
    int          err_cnt = 0;
    int          cyc = 0;
    int          wr_cnt = 0;
    int          last_we_cyc = 0;
    int          prev_we_cyc = 0;
    logic [31:0] last_addr = 32'd0;
    logic [7:0]  tb_sum = 8'd0;

    inst_mem_loader #(.MAX_WORDS(1024)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .word_count (word_count),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard: write monitor ----------------
    always @(negedge clk) begin
        if (mem_we) begin
            logic [W-1:0] exp_v;
            wr_cnt      = wr_cnt + 1;
            prev_we_cyc = last_we_cyc;
            last_we_cyc = cyc;
            last_addr   = mem_addr;
            vec_cnt     = vec_cnt + 1;
            assert (exp_q.size() != 0) else begin
                err_cnt = err_cnt + 1;
                $error("FAIL unexpected_write: observed addr=%08h data=%08h expected no write",
                       mem_addr, mem_wdata);
            end
            if (exp_q.size() != 0) begin
                exp_v   = exp_q.pop_front();
                vec_cnt = vec_cnt + 1;
                assert ({mem_addr, mem_wdata} === exp_v) else begin
                    err_cnt = err_cnt + 1;
                    $error("FAIL write_data: observed addr=%08h data=%08h expected addr=%08h data=%08h",
                           mem_addr, mem_wdata, exp_v[63:32], exp_v[31:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vec_cnt = vec_cnt + 1;
        assert (obs === exp_v) else begin
            err_cnt = err_cnt + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Holds byte_valid until the byte is accepted on a rising edge.
    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard      = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && guard < 20) begin
            tick();
            guard++;
        end
        if (guard >= 20) begin
            chk("byte_ready_timeout", 32'(byte_ready), 32'd1);
        end
        tick();
        byte_valid = 1'b0;
        tb_sum     = tb_sum + b;
    endtask

    task automatic do_start(input logic [10:0] wc);
        start      = 1'b1;
        word_count = wc;
        tick();
        start      = 1'b0;
        tb_sum     = 8'd0;
    endtask

    // Drives one word LSB first; expectation is queued before the 4th byte.
    task automatic feed_word(input logic [31:0] w, input int idx, input bit gaps);
        for (int b = 0; b < 4; b++) begin
            if (b == 3) exp_q.push_back({32'(idx * 4), w});
            send_byte(w[8*b +: 8]);
            if (gaps) tick();
        end
    endtask

    // Closes a load; with the checksum stage a matching checksum byte is sent.
    task automatic finish_load();
`ifdef CHECKSUM_EN
        send_byte(8'h00 - tb_sum);
`endif
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int wr_base;

        rst        = 1'b1;
        start      = 1'b0;
        word_count = 11'd0;
        byte_valid = 1'b0;
        byte_data  = 8'd0;
        tick();
        tick();

        // Reset state
        chk("rst_byte_ready", 32'(byte_ready), 32'd0);
        chk("rst_mem_we",     32'(mem_we),     32'd0);
        chk("rst_busy",       32'(busy),       32'd0);
        chk("rst_done",       32'(done),       32'd0);
        chk("rst_error",      32'(error),      32'd0);
        chk("rst_cpu_hold",   32'(cpu_hold),   32'd1);
        chk("rst_mem_addr",   mem_addr,        32'd0);
        chk("rst_mem_wdata",  mem_wdata,       32'd0);
        rst = 1'b0;
        tick();
        chk("idle_byte_ready", 32'(byte_ready), 32'd0);

        // Two-word load with continuous valid
        wr_base = wr_cnt;
        do_start(11'd2);
        chk("load_busy",       32'(busy),       32'd1);
        chk("load_byte_ready", 32'(byte_ready), 32'd1);
        chk("load_cpu_hold",   32'(cpu_hold),   32'd1);
        feed_word(32'h20010028, 0, 1'b0);
        feed_word(32'h20050000, 1, 1'b0);
        finish_load();
        chk("two_done",     32'(done),     32'd1);
        chk("two_cpu_hold", 32'(cpu_hold), 32'd0);
        chk("two_busy",     32'(busy),     32'd0);
        tick();
        chk("two_writes",    32'(wr_cnt - wr_base),           32'd2);
        chk("two_write_gap", 32'(last_we_cyc - prev_we_cyc),  32'd4);
        chk("two_error",     32'(error),                      32'd0);

        // Back-pressure: valid on every other cycle
        wr_base = wr_cnt;
        do_start(11'd1);
        feed_word(32'hAABBCCDD, 0, 1'b1);
        finish_load();
        tick();
        chk("bp_writes", 32'(wr_cnt - wr_base), 32'd1);
        chk("bp_done",   32'(done),             32'd1);

        // Restart from DONE
        wr_base = wr_cnt;
        do_start(11'd1);
        chk("rs_done",     32'(done),     32'd0);
        chk("rs_error",    32'(error),    32'd0);
        chk("rs_cpu_hold", 32'(cpu_hold), 32'd1);
        feed_word($urandom_range(0, 32'h7FFF_FFFF), 0, 1'b0);
        finish_load();
        tick();
        chk("rs_writes", 32'(wr_cnt - wr_base), 32'd1);
        chk("rs_addr",   last_addr,             32'd0);

        // Start ignored during LOAD, then reset after 6 bytes of a 3-word load
        wr_base = wr_cnt;
        do_start(11'd3);
        feed_word(32'h11223344, 0, 1'b0);
        start      = 1'b1;
        word_count = 11'd0;
        send_byte(8'h55);
        start      = 1'b0;
        chk("start_ignored_busy", 32'(busy), 32'd1);
        send_byte(8'h66);
        rst = 1'b1;
        tick();
        chk("mid_rst_busy",       32'(busy),       32'd0);
        chk("mid_rst_cpu_hold",   32'(cpu_hold),   32'd1);
        chk("mid_rst_done",       32'(done),       32'd0);
        chk("mid_rst_byte_ready", 32'(byte_ready), 32'd0);
        chk("mid_rst_mem_we",     32'(mem_we),     32'd0);
        chk("mid_rst_mem_addr",   mem_addr,        32'd0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("mid_rst_writes",     32'(wr_cnt - wr_base), 32'd1);
        chk("mid_rst_idle_ready", 32'(byte_ready),       32'd0);
        chk("mid_rst_exp_empty",  32'(exp_q.size()),     32'd0);

        // word_count = 0: DONE on the next cycle, no writes
        wr_base = wr_cnt;
        do_start(11'd0);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_busy", 32'(busy), 32'd0);
        byte_valid = 1'b1;
        byte_data  = 8'hA5;
        for (int i = 0; i < 4; i++) tick();
        byte_valid = 1'b0;
        chk("zero_writes", 32'(wr_cnt - wr_base), 32'd0);
        chk("zero_error",  32'(error),            32'd0);

        // word_count = 2000 clamps to MAX_WORDS
        wr_base = wr_cnt;
        do_start(11'd2000);
        for (int i = 0; i < 1024; i++) begin
            feed_word($urandom, i, 1'b0);
        end
        chk("max_ready_after", 32'(byte_ready), 32'(0)
`ifdef CHECKSUM_EN
            + 32'd1
`endif
        );
        finish_load();
        tick();
        chk("max_writes",    32'(wr_cnt - wr_base), 32'd1024);
        chk("max_last_addr", last_addr,             32'h0000_0FFC);
        chk("max_done",      32'(done),             32'd1);
        chk("max_exp_empty", 32'(exp_q.size()),     32'd0);

`ifdef CHECKSUM_EN
        // Checksum good / bad
        do_start(11'd1);
        feed_word(32'h04030201, 0, 1'b0);
        chk("cs_in_check_busy", 32'(busy), 32'd1);
        send_byte(8'hF6);
        chk("cs_good_error", 32'(error), 32'd0);
        chk("cs_good_done",  32'(done),  32'd1);
        do_start(11'd1);
        feed_word(32'h04030201, 0, 1'b0);
        send_byte(8'hF7);
        chk("cs_bad_error", 32'(error), 32'd1);
        chk("cs_bad_done",  32'(done),  32'd1);
        do_start(11'd0);
        chk("cs_clear_error", 32'(error), 32'd0);
`endif

        tick();
        chk("final_exp_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/inst_mem_loader.md
INST_MEM_LOADER -- requirements
Module: inst_mem_loader

Interface
REQ-001 The block SHALL have parameter MAX_WORDS, default 1024, meaning the instruction-memory depth in 32-bit words.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  input  1  sole clock, rising edge
- rst  input  1  synchronous active-high reset
- start  input  1  begin a load; sampled only in IDLE or DONE
- word_count  input  11  number of words to load; latched on an accepted start
- byte_valid  input  1  byte_data is valid this cycle
- byte_data  input  8  incoming program byte stream
- byte_ready  output  1  loader accepts byte_data this cycle
- mem_we  output  1  instruction-memory write strobe, one cycle per word
- mem_addr  output  32  byte address of the written word; bits [1:0] always 0
- mem_wdata  output  32  word being written
- cpu_hold  output  1  holds the processor off instruction fetch
- busy  output  1  load in progress
- done  output  1  load finished; level signal
- error  output  1  checksum mismatch; level signal

Function
REQ-004 FSM states SHALL be IDLE, LOAD, CHECK and DONE; CHECK exists only when CHECKSUM_EN is defined.
REQ-005 IDLE/DONE + start with word_count = 0 SHALL go to DONE and clear error; no writes occur.
REQ-006 IDLE/DONE + start with word_count != 0 SHALL go to LOAD, latch min(word_count, MAX_WORDS), and clear the word index, byte index, running sum, done and error.
REQ-007 start SHALL be ignored in LOAD and CHECK.
REQ-008 byte_ready SHALL be 1 only in LOAD and CHECK; a byte is accepted on a cycle where byte_valid and byte_ready are both 1.
REQ-009 Bytes SHALL assemble little-endian: the 1st accepted byte of a word goes to [7:0] and the 4th to [31:24].
REQ-010 On the cycle after the 4th byte is accepted, the block SHALL drive mem_we=1 for exactly one cycle, with mem_addr = word_index*4 and mem_wdata = the assembled word; the word index then increments.
REQ-011 Byte acceptance SHALL continue without bubbles while a write is in flight; sustained valid gives one word write every 4 cycles.
REQ-012 After the write of the last word (index = latched count - 1), the FSM SHALL go to CHECK if CHECKSUM_EN is defined, otherwise to DONE.
REQ-013 mem_we SHALL never assert outside LOAD, except for the final write, which completes on the transition cycle.
REQ-014 Word index SHALL never exceed MAX_WORDS-1; no address wrap-around occurs.
REQ-015 busy SHALL be 1 in LOAD and CHECK, otherwise 0.
REQ-016 done SHALL be 1 in DONE, otherwise 0.
REQ-017 cpu_hold SHALL be 1 in IDLE, LOAD and CHECK, and 0 only in DONE.
REQ-018 Accepted bytes SHALL have no effect in IDLE or DONE; byte_ready is 0 there, so no bytes are accepted.

Reset
REQ-019 rst SHALL force IDLE and set: byte_ready, mem_we, busy, done, error, indices and sum = 0; mem_addr and mem_wdata = 0; cpu_hold = 1.
REQ-020 rst asserted mid-load SHALL abort the load on that edge with no further mem_we; words already written stay in memory; a partially assembled word is discarded.

Configuration
REQ-021 With CHECKSUM_EN defined, the block SHALL keep an 8-bit modulo-256 sum of all data bytes, and in CHECK accept exactly one checksum byte, then go to DONE with error=1 iff (sum + checksum byte) mod 256 != 0.
REQ-022 Without CHECKSUM_EN, the block SHALL have no CHECK state and no sum register, and error SHALL be tied to 0.
REQ-023 Port list and timing of all other signals SHALL be identical in both builds.

Verification
REQ-024 Load 2 words: start with word_count=2, bytes 28,00,01,20 then 00,00,05,20 with continuous valid -> mem_we at addr 0x0 with wdata 0x20010028, then at addr 0x4 with wdata 0x20050000, 4 cycles apart; then done=1 and cpu_hold=0.
REQ-025 Back-pressure: byte_valid toggled every other cycle while loading 1 word 0xAABBCCDD -> exactly one write with wdata 0xAABBCCDD; no write before the 4th byte.
REQ-026 Reset mid-load: rst asserted after 6 bytes of a 3-word load -> exactly 1 write occurred; after rst, state is IDLE, cpu_hold=1, done=0 and byte_ready=0.
REQ-027 Boundaries: word_count=0 -> done on the next cycle with no writes; word_count=2000 -> 1024 writes, the last at addr 0xFFC.
REQ-028 CHECKSUM_EN defined: bytes 01,02,03,04 then checksum F6 -> error=0; checksum F7 -> error=1; done=1 in both cases.
REQ-029 Restart from DONE: start with word_count=1 -> done=0, error=0, cpu_hold=1, and the new word is written at addr 0x0.
